// File: rtl/rv32_fetch_unit_pkg.sv
// Shared types for the RV32 instruction fetch path: instruction word,
// fetch FSM encoding and the default boot address.
package rv32_types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Small circular buffer of {pc, instruction} pairs between memory and decode.
// Clear wins over push/pop; push into a full buffer is accepted only alongside a pop.
module rv32_fetch_fifo #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [31:0]   i_push_pc,
  input  logic [31:0]   i_push_instr,
  input  logic          i_pop,
  input  logic          i_clear,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic [31:0]   o_head_pc,
  output logic [31:0]   o_head_instr
);

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_pc[r_wr]    <= i_push_pc;
        r_instr[r_wr] <= i_push_instr;
        r_wr          <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Head reads as zero when empty so decode never sees a stale word.
  assign o_head_pc    = o_empty ? '0 : r_pc[r_rd];
  assign o_head_instr = o_empty ? '0 : r_instr[r_rd];

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 fetch unit: single-outstanding instruction memory requests feeding a
// small buffer towards decode, with redirect (flush + restart) support.
module rv32_fetch_unit
  import rv32_types::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // raised imem_req_valid keeps its address until accepted or redirected.
  fetch_state_t  r_state;
  fetch_state_t  w_next_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pend_pc;
  logic          r_req_valid;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_next_count;
  instr_t        w_head_instr;
  logic [31:0]   w_head_pc;

  assign w_req_fire = r_req_valid && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (redirect_valid)  w_next_state = w_req_fire ? ST_DRAIN : ST_FETCH;
        else if (w_req_fire) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid)      w_next_state = ST_FETCH;
        else if (redirect_valid) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) w_next_state = ST_FETCH;
      end
      default: w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    w_push       = (r_state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    w_pop        = !w_fifo_empty && out_ready;
    w_clear      = redirect_valid;
    w_next_count = '0;
    if (!w_clear)
      w_next_count = w_count + CW'(w_push && (!w_fifo_full || w_pop)) - CW'(w_pop);
  end

  // Request valid is precomputed so it is a pure register at the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_pend_pc   <= '0;
      r_req_valid <= 1'b0;
    end else begin
      r_req_valid <= (w_next_state == ST_FETCH) && (w_next_count < CW'(FIFO_DEPTH));
      if (w_req_fire) r_pend_pc <= r_fetch_pc;
      if (redirect_valid)  r_fetch_pc <= word_align(redirect_pc);
      else if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  rv32_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_pc    (r_pend_pc),
    .i_push_instr (imem_rsp_data),
    .i_pop        (w_pop),
    .i_clear      (w_clear),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_count      (w_count),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign out_valid      = !w_fifo_empty;
  assign out_instr      = w_head_instr;
  assign out_pc         = w_head_pc;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Bench for rv32_fetch_unit: a responding memory model plus a scoreboard that
// predicts the decode stream from program-order PCs, flushes and buffer capacity.
module tb_rv32_fetch_unit;
  import rv32_types::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        out_valid;
  logic        out_ready      = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  rv32_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .dbg_state      (dbg_state)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];        // {pc, instr} expected to reach decode, in order
  logic        m_out   = 1'b0;  // memory holds an accepted, unanswered request
  logic        m_stale = 1'b0;  // that request was overtaken by a redirect
  int          m_cd    = 0;
  logic [31:0] m_addr     = '0;
  logic [31:0] m_addr_exp = '0;
  logic [31:0] m_req_pc   = RST_PC;
  int          p_ready = 100, p_out = 100, p_redir = 0, max_delay = 1;
  logic        f_redir = 1'b0, f_out = 1'b0;
  logic [31:0] f_redir_pc = '0;
  logic        found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: check outputs, drive inputs for the next rising
  // edge, advance the model by that edge, then wait for the next falling edge.
  task automatic step();
    logic        fire, pop, rsp;
    logic [1:0]  es;
    logic [63:0] head;
    check("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("out_pc", out_pc, head[63:32]);
      check("out_instr", out_instr, head[31:0]);
    end
    check("req_valid", imem_req_valid, !m_out && (exp_q.size() < DEPTH));
    if (imem_req_valid) check("req_addr", imem_req_addr, m_req_pc);
    es = !m_out ? ST_FETCH : (m_stale ? ST_DRAIN : ST_WAIT);
    check("state", dbg_state, es);

    imem_req_ready = ($urandom_range(99) < p_ready);
    out_ready      = f_out ? 1'b1 : ($urandom_range(99) < p_out);
    rsp            = m_out && (m_cd == 1);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(m_addr) : $urandom();
    if (f_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_redir_pc;
    end else begin
      redirect_valid = ($urandom_range(99) < p_redir);
      redirect_pc    = $urandom();
    end
    f_redir = 1'b0;
    f_out   = 1'b0;

    fire = imem_req_valid && imem_req_ready;
    pop  = (exp_q.size() > 0) && out_ready;
    if (pop) void'(exp_q.pop_front());
    if (rsp) begin
      if (!m_stale && !redirect_valid) exp_q.push_back({m_addr_exp, mem_word(m_addr_exp)});
      m_out   = 1'b0;
      m_stale = 1'b0;
    end else if (m_out) begin
      m_cd--;
    end
    if (fire) begin
      m_out      = 1'b1;
      m_stale    = 1'b0;
      m_addr     = imem_req_addr;
      m_addr_exp = m_req_pc;
      m_cd       = $urandom_range(max_delay, 1);
      m_req_pc   = m_req_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      if (m_out) m_stale = 1'b1;
      m_req_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_req_addr"}, imem_req_addr, RST_PC);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_instr"}, out_instr, 32'h0);
    check({tag, "_out_pc"}, out_pc, 32'h0);
    check({tag, "_state"}, dbg_state, ST_FETCH);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    reset_checks("rst_in");
    @(negedge clk);
    reset_checks("rst_hold");
    rst = 1'b0;
    exp_q.delete();
    m_out    = 1'b0;
    m_stale  = 1'b0;
    m_req_pc = RST_PC;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Straight-line fetch with a single-cycle memory and a ready decoder.
    p_ready = 100; p_out = 100; p_redir = 0; max_delay = 1;
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, RST_PC);
    repeat (20) step();

    // Decoder stall: buffer fills and requests stop, then drains without loss.
    p_out = 0;
    repeat (10) step();
    check("stall_req_off", imem_req_valid, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    p_out = 100;
    repeat (10) step();

    // Redirect while the fetch of 0x8 is in flight.
    max_delay = 3;
    f_redir = 1'b1; f_redir_pc = 32'h0;
    step();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_out && !m_stale && m_addr_exp == 32'h8) begin
        found = 1'b1; f_redir = 1'b1; f_redir_pc = 32'h100;
      end
      step();
    end
    check("redir_window", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else step();
    end
    check("redir_out_seen", found, 1'b1);
    check("redir_first_pc", out_pc, 32'h100);
    check("redir_first_instr", out_instr, mem_word(32'h100));

    // Unaligned redirect target.
    f_redir = 1'b1; f_redir_pc = 32'h203;
    step();
    check("align_addr", imem_req_addr, 32'h200);

    // Memory back-pressure near the top of the address space, then wrap.
    p_ready = 0;
    f_redir = 1'b1; f_redir_pc = 32'hFFFF_FFF8;
    step();
    repeat (5) step();
    check("hold_valid", imem_req_valid, 1'b1);
    check("hold_addr", imem_req_addr, 32'hFFFF_FFF8);
    p_ready = 100;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (imem_req_valid && imem_req_addr == 32'h0) found = 1'b1;
      step();
    end
    check("wrap_to_zero", found, 1'b1);

    // Redirect coinciding with a response and a decode pop.
    max_delay = 1; p_out = 0;
    f_redir = 1'b1; f_redir_pc = 32'h300;
    step();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (exp_q.size() > 0 && m_out && !m_stale && m_cd == 1) begin
        found = 1'b1; f_out = 1'b1; f_redir = 1'b1; f_redir_pc = 32'h400;
      end
      step();
    end
    check("flush_window", found, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_state", dbg_state, ST_FETCH);
    p_out = 100;
    repeat (10) step();

    // Random traffic, a reset in the middle of it, then more traffic.
    p_ready = 70; p_out = 70; p_redir = 5; max_delay = 3;
    repeat (600) step();
    do_reset();
    repeat (200) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_fetch_unit.md
RV32_FETCH_UNIT -- requirements
Module: rv32_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, default 2, fetched-instruction buffer entries; legal values are 2 and 4.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 Port: imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 Port: imem_req_addr  output  32  word-aligned fetch address.
REQ-008 Port: imem_rsp_valid  input  1  read data valid; exactly one response per accepted request, no earlier than 1 cycle after acceptance.
REQ-009 Port: imem_rsp_data  input  32  fetched instruction word.
REQ-010 Port: redirect_valid  input  1  flush and restart fetch (branch/jump resolved).
REQ-011 Port: redirect_pc  input  32  new fetch address.
REQ-012 Port: out_valid  output  1  instruction available to decode stage.
REQ-013 Port: out_ready  input  1  decode stage consumes this cycle.
REQ-014 Port: out_instr  output  32  instruction word, instr_t type.
REQ-015 Port: out_pc  output  32  address of out_instr.

Function
REQ-016 Handshakes: request transfers when imem_req_valid && imem_req_ready; output transfers when out_valid && out_ready.
REQ-017 Outputs imem_req_valid, out_valid, out_instr, out_pc are driven from registers only; no combinational input-to-output path except none.
REQ-018 At most one memory request outstanding.
REQ-019 FSM states: FETCH (request asserted), WAIT (one request outstanding), DRAIN (outstanding response to be discarded).
REQ-020 FETCH: imem_req_valid=1 only when FIFO occupancy < FIFO_DEPTH; on acceptance go WAIT and fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-021 WAIT: on imem_rsp_valid push {fetch address, imem_rsp_data} into FIFO, go FETCH.
REQ-022 DRAIN: on imem_rsp_valid discard data, go FETCH; nothing pushed.
REQ-023 imem_req_valid, once asserted, holds with stable imem_req_addr until accepted, unless redirect occurs.
REQ-024 out_valid rises the cycle after the pushing imem_rsp_valid (1-cycle response-to-decode latency); FIFO is first-in-first-out; push and pop in the same cycle both take effect.
REQ-025 Redirect: FIFO cleared, fetch_pc <= {redirect_pc[31:2],2'b00}; out_valid=0 next cycle; state goes DRAIN if a request is outstanding (WAIT, or request accepted this cycle), else FETCH.
REQ-026 Redirect with simultaneous imem_rsp_valid in WAIT: response discarded, state goes FETCH.
REQ-027 Redirect takes priority over simultaneous push, pop and increment; popped instruction that cycle still counts as consumed by decode.
REQ-028 Redirect during DRAIN: stay DRAIN, update fetch_pc to newest redirect_pc.
REQ-029 Throughput: with 1-cycle memory and out_ready=1, one instruction per 2 cycles (single outstanding).

Reset
REQ-030 While rst=1: state FETCH, fetch_pc=RESET_PC, FIFO empty, imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0.
REQ-031 First request (imem_req_valid=1, addr=RESET_PC) in the first cycle after rst deasserts.
REQ-032 Reset mid-transaction discards any outstanding response; memory side is reset concurrently.

Structure
REQ-033 instr_t and fetch-state enum reside in shared package rv32_types; RESET_PC default defined there as constant.
REQ-034 Buffer implemented as sub-module rv32_fetch_fifo (parameterised depth, push/pop/clear, full/empty, occupancy).

Verification
REQ-035 Reset release, 1-cycle memory, out_ready=1 -> addresses 0x0,0x4,0x8 requested; out_pc 0x0,0x4,0x8 in order with matching instr.
REQ-036 out_ready=0 for 10 cycles -> exactly FIFO_DEPTH (2) responses buffered, imem_req_valid=0 afterwards, no loss on resume.
REQ-037 Redirect to 0x100 while request to 0x8 outstanding -> 0x8 response dropped, next out_pc=0x100.
REQ-038 redirect_pc=0x203 -> imem_req_addr=0x200.
REQ-039 imem_req_ready=0 for 5 cycles -> imem_req_valid and addr stable; fetch_pc at 0xFFFF_FFFC -> next request 0x0.
REQ-040 Redirect same cycle as rsp_valid and out pop -> FIFO empty next cycle, state FETCH, no stale instruction emitted.
